// File: rtl/dma_axi_rd.sv
// dma_axi_rd: AXI4 read master for the DMA engine. Takes one burst request
// (addr, dma_len), issues a single INCR burst on AR, buffers R beats in a
// 2-entry FIFO and hands them to the consumer over a valid/ready databus.
// Ports: clk, rst_n (sync, active low); request valid/addr/dma_len, status
// dma_ready/error; databus rdata/data_valid/data_last/data_ready;
// AXI4 AR channel (m_axi_ar*) and R channel (m_axi_r*).
module dma_axi_rd #(
  parameter int AXI_ADDR_W = 32,
  parameter int ADDR_W     = AXI_ADDR_W,
  parameter int DMA_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_SIZE_W = 3,
  parameter int AXI_RESP_W = 2,
  parameter int AXI_ID_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [AXI_LEN_W-1:0]  dma_len,
  output logic                  dma_ready,
  output logic                  error,
  output logic [DMA_DATA_W-1:0] rdata,
  output logic                  data_valid,
  output logic                  data_last,
  input  logic                  data_ready,
  output logic [AXI_ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [AXI_LEN_W-1:0]  m_axi_arlen,
  output logic [AXI_SIZE_W-1:0] m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DMA_DATA_W-1:0] m_axi_rdata,
  input  logic [AXI_RESP_W-1:0] m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int SIZE = $clog2(DMA_DATA_W / 8);
  localparam logic [AXI_LEN_W:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    R_ADDR_HS = 2'd0,
    R_DATA    = 2'd1,
    R_DRAIN   = 2'd2
  } state_t;

  state_t                 state;
  logic [AXI_LEN_W-1:0]   len_r;
  logic [AXI_LEN_W:0]     cnt;
  logic [1:0]             count;
  logic [DMA_DATA_W-1:0]  d0, d1;
  logic                   l0, l1;
  logic                   push, pop;
  logic                   cnt_hit, beat_last;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = dma_len;
  assign m_axi_arsize  = SIZE[AXI_SIZE_W-1:0];
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'h2;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = 4'h0;

  assign m_axi_arvalid = (state == R_ADDR_HS) & valid & rst_n;
  assign m_axi_rready  = (state == R_DATA) & (count < 2'd2) & rst_n;

  assign push      = m_axi_rvalid & m_axi_rready;
  assign pop       = data_valid & data_ready;
  assign cnt_hit   = (cnt == {1'b0, len_r});
  // Either side ending the burst closes it; a disagreement is flagged.
  assign beat_last = cnt_hit | m_axi_rlast;

  assign rdata      = d0;
  assign data_valid = (count != 2'd0);
  assign data_last  = l0 & data_valid;

  // Two-entry FIFO: d0 is always the head, d1 the second slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      d0    <= '0;
      d1    <= '0;
      l0    <= 1'b0;
      l1    <= 1'b0;
    end else if (push && !pop) begin
      if (count == 2'd0) begin
        d0 <= m_axi_rdata;
        l0 <= beat_last;
      end else begin
        d1 <= m_axi_rdata;
        l1 <= beat_last;
      end
      count <= count + 2'd1;
    end else if (!push && pop) begin
      d0    <= d1;
      l0    <= l1;
      count <= count - 2'd1;
    end else if (push && pop) begin
      d0 <= m_axi_rdata;
      l0 <= beat_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= R_ADDR_HS;
      dma_ready <= 1'b1;
      error     <= 1'b0;
      len_r     <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        R_ADDR_HS: begin
          dma_ready <= !valid;
          if (valid && m_axi_arready) begin
            len_r <= dma_len;
            cnt   <= '0;
            error <= 1'b0;
            state <= R_DATA;
          end
        end
        R_DATA: begin
          dma_ready <= 1'b0;
          if (push) begin
            cnt <= cnt + CNT_ONE;
            if (m_axi_rresp != '0)
              error <= 1'b1;
            if (m_axi_rlast != cnt_hit)
              error <= 1'b1;
            if (beat_last)
              state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          dma_ready <= 1'b0;
          if (count == 2'd0)
            state <= R_ADDR_HS;
        end
        default: begin
          dma_ready <= 1'b0;
          state     <= R_ADDR_HS;
        end
      endcase
    end
  end

endmodule
